// File: rtl/csr_file_if.sv
// Decoder <-> CSR file request/response bundle. The decoder drives the request,
// and the CSR file returns the old value and the illegal flag in the same cycle.
interface csr_file_if;
  typedef struct packed {
    logic        valid;
    logic        use_imm;
    logic [2:0]  csr_mode;
    logic [11:0] csr_target;
  } csr_req_t;

  csr_req_t    csr_req;
  logic [4:0]  csr_rs1_idx;
  logic [31:0] csr_rs1_data;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  modport master (output csr_req, csr_rs1_idx, csr_rs1_data, input csr_rdata, csr_illegal);
  modport slave  (input csr_req, csr_rs1_idx, csr_rs1_data, output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: CSR read/modify/write, trap and MRET
// state, 64-bit cycle/instret counters and interrupt pending/enable.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_file_if.slave   bus,
  input  logic        instret,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  input  logic        irq_msi,
  input  logic        irq_mti,
  input  logic        irq_mei,
  output logic        irq_pending
);

  logic [11:0] addr;
  logic [1:0]  mode;
  logic [31:0] src, old, wdata, tvec_base;
  logic        impl, wr_req, illegal, we;

  logic        mst_mie, mst_mpie;
  logic [2:0]  mie_q, mip_q;          // {MEIx, MTIx, MSIx}
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;

  assign addr = bus.csr_req.csr_target;
  assign mode = bus.csr_req.csr_mode[1:0];
  assign src  = bus.csr_req.use_imm ? {27'b0, bus.csr_rs1_idx} : bus.csr_rs1_data;

  always_comb begin
    impl = 1'b1;
    old  = '0;
    case (addr)
      12'h300: old = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      12'h301: old = MISA_VALUE;
      12'h304: old = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
      12'h305: old = mtvec_q;
      12'h340: old = mscratch_q;
      12'h341: old = mepc_q;
      12'h342: old = mcause_q;
      12'h343: old = mtval_q;
      12'h344: old = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
      12'hB00, 12'hC00: old = mcycle_q[31:0];
      12'hB80, 12'hC80: old = mcycle_q[63:32];
      12'hB02, 12'hC02: old = minstret_q[31:0];
      12'hB82, 12'hC82: old = minstret_q[63:32];
      12'hF14: old = HART_ID;
      default: impl = 1'b0;
    endcase
  end

  // RS/RC with x0/zimm=0 is a pure read, so it never trips the read-only check
  assign wr_req  = bus.csr_req.valid &
                   ((mode == 2'b01) | ((mode != 2'b00) & (bus.csr_rs1_idx != 5'd0)));
  assign illegal = bus.csr_req.valid & (~impl | (wr_req & (addr[11:10] == 2'b11)));
  assign we      = wr_req & ~illegal;
  assign wdata   = (mode == 2'b01) ? src : (mode == 2'b10) ? (old | src) : (old & ~src);

  assign bus.csr_rdata   = (bus.csr_req.valid & ~illegal) ? old : '0;
  assign bus.csr_illegal = illegal;

  // Vectored mode only offsets interrupts; exceptions always land on the base
  assign tvec_base   = {mtvec_q[31:2], 2'b00};
  assign trap_vector = (mtvec_q[0] & trap_cause[31]) ? tvec_base + {trap_cause[29:0], 2'b00}
                                                     : tvec_base;
  assign mepc_out    = mepc_q;
  assign irq_pending = mst_mie & |(mip_q & mie_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mip_q <= {irq_mei, irq_mti, irq_msi};

      // trap beats mret beats a CSR write on the shared trap state
      if (trap_valid) begin
        mst_mie  <= 1'b0;
        mst_mpie <= mst_mie;
      end else if (mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (we && addr == 12'h300) begin
        mst_mie  <= wdata[3];
        mst_mpie <= wdata[7];
      end

      if (trap_valid) begin
        mepc_q   <= {trap_pc[31:2], 2'b00};
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
      end else if (we) begin
        case (addr)
          12'h341: mepc_q   <= {wdata[31:2], 2'b00};
          12'h342: mcause_q <= wdata;
          12'h343: mtval_q  <= wdata;
          default: ;
        endcase
      end

      if (we && addr == 12'h304) mie_q <= {wdata[11], wdata[7], wdata[3]};
      if (we && addr == 12'h305) mtvec_q <= {wdata[31:2], 1'b0, wdata[0]};
      if (we && addr == 12'h340) mscratch_q <= wdata;

      // a write to either half replaces that cycle's increment, no carry
      if (we && addr == 12'hB00)      mcycle_q[31:0]  <= wdata;
      else if (we && addr == 12'hB80) mcycle_q[63:32] <= wdata;
      else                            mcycle_q        <= mcycle_q + 64'd1;

      if (we && addr == 12'hB02)      minstret_q[31:0]  <= wdata;
      else if (we && addr == 12'hB82) minstret_q[63:32] <= wdata;
      else if (instret)               minstret_q        <= minstret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Randomized and directed bench for csr_file, checked against a CSR-level
// reference model that tracks each architectural register directly.
module tb_csr_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_file_if bus();
  logic        instret, trap_valid, mret, irq_msi, irq_mti, irq_mei, irq_pending;
  logic [31:0] trap_cause, trap_pc, trap_tval, trap_vector, mepc_out;

  csr_file dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .instret(instret), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret),
    .trap_vector(trap_vector), .mepc_out(mepc_out),
    .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei),
    .irq_pending(irq_pending)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference state
  bit        m_mie, m_mpie;
  bit [31:0] m_mie_reg, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  bit [63:0] m_cyc, m_inst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mip = 0; m_mtvec = 0;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_inst = 0;
  endtask

  function automatic bit mread(input bit [11:0] a, output bit [31:0] v);
    v = 0;
    mread = 1;
    case (a)
      12'h300: v = (32'd3 << 11) | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_inst[31:0];
      12'hB82, 12'hC82: v = m_inst[63:32];
      12'hF14: v = 32'd0;
      default: mread = 0;
    endcase
  endfunction

  task automatic drive(input bit v, input bit imm, input bit [1:0] md, input bit [11:0] a,
                       input bit [4:0] idx, input bit [31:0] d);
    bus.csr_req.valid      = v;
    bus.csr_req.use_imm    = imm;
    bus.csr_req.csr_mode   = {imm, md};
    bus.csr_req.csr_target = a;
    bus.csr_rs1_idx        = idx;
    bus.csr_rs1_data       = d;
  endtask

  task automatic idle();
    drive(0, 0, 2'b10, 12'h000, 5'd0, 32'd0);
  endtask

  task automatic rd(input bit [11:0] a);
    drive(1, 0, 2'b10, a, 5'd0, 32'd0);
  endtask

  // check one cycle of combinational outputs, then advance the model over the edge
  task automatic step();
    bit [31:0] ov, src, nv, base, tv;
    bit [11:0] a;
    bit [1:0]  md;
    bit        v, ok, wr, ill, we;
    bit        n_mie, n_mpie;
    bit [31:0] n_mie_reg, n_mip, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval;
    bit [63:0] n_cyc, n_inst;
    #1;
    v   = bus.csr_req.valid;
    a   = bus.csr_req.csr_target;
    md  = bus.csr_req.csr_mode[1:0];
    ok  = mread(a, ov);
    src = bus.csr_req.use_imm ? 32'(bus.csr_rs1_idx) : bus.csr_rs1_data;
    wr  = v && (md == 2'b01 || (md != 2'b00 && bus.csr_rs1_idx != 0));
    ill = v && (!ok || (wr && a[11:10] == 2'b11));
    we  = wr && !ill;
    base = m_mtvec & ~32'h3;
    tv   = (m_mtvec[0] && trap_cause[31]) ? base + (32'(trap_cause[30:0]) << 2) : base;
    chk("rdata", bus.csr_rdata, (v && !ill) ? ov : 32'd0);
    chk("illegal", 32'(bus.csr_illegal), 32'(ill));
    chk("trap_vector", trap_vector, tv);
    chk("mepc_out", mepc_out, m_mepc);
    chk("irq_pending", 32'(irq_pending), 32'(m_mie && ((m_mie_reg & m_mip) != 0)));

    nv = (md == 2'b01) ? src : (md == 2'b10) ? (ov | src) : (ov & ~src);
    n_mie = m_mie; n_mpie = m_mpie; n_mie_reg = m_mie_reg; n_mtvec = m_mtvec;
    n_mscratch = m_mscratch; n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
    n_mip  = (32'(irq_mei) << 11) | (32'(irq_mti) << 7) | (32'(irq_msi) << 3);
    n_cyc  = m_cyc + 1;
    n_inst = m_inst + (instret ? 64'd1 : 64'd0);
    if (we) begin
      case (a)
        12'h300: if (!trap_valid && !mret) begin n_mie = nv[3]; n_mpie = nv[7]; end
        12'h304: n_mie_reg = nv & 32'h888;
        12'h305: n_mtvec = nv & ~32'h2;
        12'h340: n_mscratch = nv;
        12'h341: if (!trap_valid) n_mepc = nv & ~32'h3;
        12'h342: if (!trap_valid) n_mcause = nv;
        12'h343: if (!trap_valid) n_mtval = nv;
        12'hB00: n_cyc  = {m_cyc[63:32], nv};
        12'hB80: n_cyc  = {nv, m_cyc[31:0]};
        12'hB02: n_inst = {m_inst[63:32], nv};
        12'hB82: n_inst = {nv, m_inst[31:0]};
        default: ;
      endcase
    end
    if (mret && !trap_valid) begin n_mie = m_mpie; n_mpie = 1; end
    if (trap_valid) begin
      n_mpie = m_mie; n_mie = 0;
      n_mepc = trap_pc & ~32'h3; n_mcause = trap_cause; n_mtval = trap_tval;
    end
    @(posedge clk);
    if (!rst_n) mreset();
    else begin
      m_mie = n_mie; m_mpie = n_mpie; m_mie_reg = n_mie_reg; m_mip = n_mip; m_mtvec = n_mtvec;
      m_mscratch = n_mscratch; m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
      m_cyc = n_cyc; m_inst = n_inst;
    end
    @(negedge clk);
  endtask

  bit [11:0] addrs [22] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                            12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                            12'hC02, 12'hC80, 12'hC82, 12'hF14, 12'h302, 12'h7C0, 12'hFFF,
                            12'hC01};

  initial begin
    instret = 0; trap_valid = 0; mret = 0; irq_msi = 0; irq_mti = 0; irq_mei = 0;
    trap_cause = 0; trap_pc = 0; trap_tval = 0;
    idle();
    mreset();
    #12;
    chk("rst_rdata", bus.csr_rdata, 32'd0);
    chk("rst_illegal", 32'(bus.csr_illegal), 32'd0);
    chk("rst_trap_vector", trap_vector, 32'd0);
    chk("rst_mepc", mepc_out, 32'd0);
    chk("rst_irq", 32'(irq_pending), 32'd0);
    @(negedge clk);
    rst_n = 1;

    drive(1, 0, 2'b01, 12'h340, 5'd5, 32'hDEAD_BEEF); #1;
    chk("rw_mscratch_old", bus.csr_rdata, 32'd0); step();
    rd(12'h340); #1;
    chk("mscratch_rd", bus.csr_rdata, 32'hDEAD_BEEF); step();
    rd(12'h300); #1;
    chk("rs_x0_illegal", 32'(bus.csr_illegal), 32'd0);
    chk("mstatus_rst", bus.csr_rdata, 32'h0000_1800); step();
    drive(1, 1, 2'b10, 12'h300, 5'd8, 32'd0); step();
    rd(12'h300); #1;
    chk("csrrsi_mie", bus.csr_rdata, 32'h0000_1808); step();
    drive(1, 0, 2'b01, 12'hF14, 5'd1, 32'h1234); #1;
    chk("rw_mhartid_ill", 32'(bus.csr_illegal), 32'd1); step();
    rd(12'hF14); #1;
    chk("rd_mhartid_ill", 32'(bus.csr_illegal), 32'd0); step();

    drive(1, 0, 2'b01, 12'h305, 5'd2, 32'h0000_0101); step();
    idle(); trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h203; trap_tval = 32'h55; #1;
    chk("vec_target", trap_vector, 32'h0000_011C); step();
    trap_valid = 0;
    rd(12'h342); #1; chk("mcause", bus.csr_rdata, 32'h8000_0007); step();
    rd(12'h300); #1; chk("trap_mstatus", bus.csr_rdata, 32'h0000_1880);
    chk("trap_mepc", mepc_out, 32'h0000_0200); step();
    idle(); mret = 1; step(); mret = 0;
    rd(12'h300); #1; chk("mret_mstatus", bus.csr_rdata, 32'h0000_1888); step();

    drive(1, 0, 2'b01, 12'hB80, 5'd1, 32'd0); step();
    drive(1, 0, 2'b01, 12'hB00, 5'd1, 32'hFFFF_FFFF); step();
    idle(); step();
    rd(12'hB00); #1; chk("mcycle_wrap", bus.csr_rdata, 32'd0); step();
    rd(12'hB80); #1; chk("mcycleh_carry", bus.csr_rdata, 32'd1); step();
    instret = 1; drive(1, 0, 2'b01, 12'hB02, 5'd1, 32'h55); step(); instret = 0;
    rd(12'hB02); #1; chk("minstret_wr_wins", bus.csr_rdata, 32'h55); step();

    drive(1, 0, 2'b01, 12'h304, 5'd1, 32'h80); step();
    idle(); irq_mti = 1; step(); step(); #1;
    chk("irq_pending_mti", 32'(irq_pending), 32'd1);
    irq_mti = 0;
    drive(1, 0, 2'b01, 12'h341, 5'd3, 32'h888); trap_valid = 1; trap_pc = 32'h404; step();
    trap_valid = 0; idle(); #1;
    chk("trap_over_csr", mepc_out, 32'h0000_0404); step();

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        rst_n = 0; mreset(); #1;
        chk("midrst_mepc", mepc_out, 32'd0);
        chk("midrst_irq", 32'(irq_pending), 32'd0);
      end
      if (i == 301) rst_n = 1;
      drive($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom_range(1, 3)),
            addrs[$urandom_range(0, 21)],
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
      instret    = 1'($urandom);
      trap_valid = ($urandom_range(0, 11) == 0);
      mret       = ($urandom_range(0, 11) == 0);
      trap_cause = {1'($urandom), 25'd0, 6'($urandom)};
      trap_pc    = $urandom;
      trap_tval  = $urandom;
      if ($urandom_range(0, 9) == 0) irq_msi = ~irq_msi;
      if ($urandom_range(0, 9) == 0) irq_mti = ~irq_mti;
      if ($urandom_range(0, 9) == 0) irq_mei = ~irq_mei;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
